cmos_pixel_capture: RTL and testbench

Parametrised CMOS sensor capture front-end, successor to the fixed 16-bit camera capture path. Samples the sensor byte stream (HREF/VSYNC framed) in the system clock domain. Assembles multi-byte pixels, applies a runtime crop window and power-of-two decimation, and queues pixels into an internal output FIFO with a valid/ready interface. Adds frame/line markers, overflow detection with frame-drop recovery, and a frame counter. Sits between the sensor pin sampler and the frame-buffer writer.

---
 rtl/cmos_pixel_capture.sv | 228 ++++++++++++++++++++++
 tb/tb_cmos_pixel_capture.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_pixel_capture.sv
// CMOS sensor capture: assembles pixels from bytes, crops and decimates them, and queues them for a valid/ready sink.
// Latency: a kept pixel raises pix_vld 2 cycles after its last byte. Backpressure: a full FIFO drops the rest of the frame.

// Show-ahead FIFO. Full comes from the registered count, and rd_dat reads 0 while the FIFO is empty.
module cmos_pix_fifo #(
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_wr_vld,
   input  logic [W-1:0] i_wr_dat,
   output logic         o_full,
   output logic         o_rd_vld,
   input  logic         i_rd_rdy,
   output logic [W-1:0] o_rd_dat
);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [2**AW];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_cnt;
   logic          w_wr;
   logic          w_rd;

   assign o_full   = (r_cnt == CW'(2**AW));
   assign o_rd_vld = (r_cnt != '0);
   assign w_wr     = i_wr_vld && !o_full;
   assign w_rd     = o_rd_vld && i_rd_rdy;
   assign o_rd_dat = o_rd_vld ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      end
   end
endmodule

module cmos_pixel_capture #(
   parameter int BYTE_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int X_W           = 11,
   parameter int Y_W           = 10,
   parameter int FIFO_DEPTH_W  = 3,
   parameter int FRAME_CNT_W   = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmos_vsync,
   input  logic                            cmos_href,
   input  logic [BYTE_W-1:0]               cmos_db,
   input  logic                            byte_vld,
   input  logic                            cfg_en,
   input  logic [X_W-1:0]                  cfg_x0,
   input  logic [X_W-1:0]                  cfg_x1,
   input  logic [Y_W-1:0]                  cfg_y0,
   input  logic [Y_W-1:0]                  cfg_y1,
   input  logic [1:0]                      cfg_decim,
   output logic [BYTE_W*BYTES_PER_PIX-1:0] pix_data,
   output logic                            pix_sof,
   output logic                            pix_eol,
   output logic                            pix_vld,
   input  logic                            pix_rdy,
   output logic                            overflow,
   output logic [FRAME_CNT_W-1:0]          frame_cnt,
   output logic                            busy
);
   localparam int PIX_W = BYTE_W * BYTES_PER_PIX;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SYNC   = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_DROP   = 2'd3;

   typedef struct packed {
      logic             sof;
      logic             eol;
      logic [PIX_W-1:0] dat;
   } pix_t;

   logic [1:0]             r_state;
   logic                   r_vsync_d;
   logic                   r_href_d;
   logic [X_W-1:0]         r_x0, r_x1, r_eol_x, r_x;
   logic [Y_W-1:0]         r_y0, r_y1, r_y;
   logic [1:0]             r_decim;
   logic [1:0]             r_byte_idx;
   logic [PIX_W-1:0]       r_shift;
   logic                   r_line_pix;
   logic                   r_sof_arm;
   logic                   r_push_vld;
   pix_t                   r_push;
   logic                   r_overflow;
   logic [FRAME_CNT_W-1:0] r_frame_cnt;

   logic                   w_vs_rise, w_vs_fall, w_latch, w_active;
   logic                   w_byte, w_href_fall, w_pix_done, w_keep, w_full, w_push_rej;
   logic [PIX_W-1:0]       w_pix_dat;
   logic [X_W-1:0]         w_mask_x, w_dx;
   logic [Y_W-1:0]         w_mask_y, w_dy;
   pix_t                   w_rd_dat;

   assign w_vs_rise   = cmos_vsync && !r_vsync_d;
   assign w_vs_fall   = !cmos_vsync && r_vsync_d;
   assign w_latch     = (r_state == ST_SYNC) && w_vs_fall && cfg_en;
   assign w_active    = (r_state == ST_ACTIVE) && cfg_en;
   assign w_byte      = w_active && byte_vld && cmos_href;
   assign w_href_fall = w_active && byte_vld && !cmos_href && r_href_d;
   assign w_pix_done  = w_byte && (r_byte_idx == 2'(BYTES_PER_PIX - 1));
   assign w_pix_dat   = (r_shift << BYTE_W) | PIX_W'(cmos_db);

   // Decimation phase is measured from the window origin, not from column/row 0.
   assign w_mask_x = ~({X_W{1'b1}} << r_decim);
   assign w_mask_y = ~({Y_W{1'b1}} << r_decim);
   assign w_dx     = r_x - r_x0;
   assign w_dy     = r_y - r_y0;
   assign w_keep   = w_pix_done && (r_x >= r_x0) && (r_x <= r_x1) && (r_y >= r_y0) && (r_y <= r_y1)
                     && ((w_dx & w_mask_x) == '0) && ((w_dy & w_mask_y) == '0);
   assign w_push_rej = r_push_vld && w_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else if (!cfg_en) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   if (cmos_vsync) r_state <= ST_SYNC;
            ST_SYNC:   if (w_vs_fall) r_state <= ST_ACTIVE;
            ST_ACTIVE: if (w_vs_rise) r_state <= ST_SYNC;
                       else if (w_push_rej) r_state <= ST_DROP;
            default:   if (w_vs_rise) r_state <= ST_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vsync_d   <= 1'b0;
         r_href_d    <= 1'b0;
         r_x0        <= '0;
         r_x1        <= '0;
         r_eol_x     <= '0;
         r_x         <= '0;
         r_y0        <= '0;
         r_y1        <= '0;
         r_y         <= '0;
         r_decim     <= '0;
         r_byte_idx  <= '0;
         r_shift     <= '0;
         r_line_pix  <= 1'b0;
         r_sof_arm   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_vsync_d <= cmos_vsync;
         if (byte_vld) r_href_d <= cmos_href;
         if (w_latch) begin
            r_x0        <= cfg_x0;
            r_x1        <= cfg_x1;
            r_y0        <= cfg_y0;
            r_y1        <= cfg_y1;
            r_decim     <= cfg_decim;
            r_eol_x     <= cfg_x0 + (((cfg_x1 - cfg_x0) >> cfg_decim) << cfg_decim);
            r_x         <= '0;
            r_y         <= '0;
            r_byte_idx  <= '0;
            r_line_pix  <= 1'b0;
            r_sof_arm   <= 1'b1;
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
         end else if (w_href_fall) begin
            r_x        <= '0;
            r_byte_idx <= '0;
            r_line_pix <= 1'b0;
            if (r_line_pix && (r_y != '1)) r_y <= r_y + Y_W'(1);
         end else if (w_byte) begin
            r_shift <= w_pix_dat;
            if (w_pix_done) begin
               r_byte_idx <= '0;
               r_x        <= r_x + X_W'(1);
               r_line_pix <= 1'b1;
            end else begin
               r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (w_keep) r_sof_arm <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_push_vld <= 1'b0;
         r_push     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_push_vld <= w_keep;
         if (w_keep) r_push <= '{sof: r_sof_arm, eol: (r_x == r_eol_x), dat: w_pix_dat};
         if (w_push_rej) r_overflow <= 1'b1;
      end
   end

   cmos_pix_fifo #(.W($bits(pix_t)), .AW(FIFO_DEPTH_W)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_wr_vld (r_push_vld),
      .i_wr_dat (r_push),
      .o_full   (w_full),
      .o_rd_vld (pix_vld),
      .i_rd_rdy (pix_rdy),
      .o_rd_dat (w_rd_dat)
   );

   assign pix_data  = w_rd_dat.dat;
   assign pix_sof   = w_rd_dat.sof;
   assign pix_eol   = w_rd_dat.eol;
   assign overflow  = r_overflow;
   assign frame_cnt = r_frame_cnt;
   assign busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Bench for cmos_pixel_capture: a frame-level pixel model predicts every popped pixel, with directed and random frames.
module tb_cmos_pixel_capture;
   localparam int BPP = 2;

   logic        clk = 1'b0;
   logic        rst, cmos_vsync, cmos_href, byte_vld, cfg_en, pix_rdy;
   logic [7:0]  cmos_db;
   logic [10:0] cfg_x0, cfg_x1;
   logic [9:0]  cfg_y0, cfg_y1;
   logic [1:0]  cfg_decim;
   logic [15:0] pix_data;
   logic        pix_sof, pix_eol, pix_vld, overflow, busy;
   logic [7:0]  frame_cnt;

   always #5 clk = ~clk;

   cmos_pixel_capture dut (
      .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_db(cmos_db),
      .byte_vld(byte_vld), .cfg_en(cfg_en), .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0),
      .cfg_y1(cfg_y1), .cfg_decim(cfg_decim), .pix_data(pix_data), .pix_sof(pix_sof),
      .pix_eol(pix_eol), .pix_vld(pix_vld), .pix_rdy(pix_rdy), .overflow(overflow),
      .frame_cnt(frame_cnt), .busy(busy)
   );

   typedef struct {
      logic [15:0] d;
      logic        sof;
      logic        eol;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0, bad = 0, cyc = 0, n_pop = 0, lat_cyc = -1, rdy_mode = 1;
   int          m_x0, m_x1, m_y0, m_y1, m_step, m_y, m_frames = 0, m_kept, m_eol_cnt, m_lim = -1;
   logic [15:0] m_first;
   bit          m_sof_seen, gap_en = 0, seq_mode = 0;
   logic [7:0]  seq_b;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      pix_rdy = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       pix_rdy = 1'b0;
            1:       pix_rdy = 1'b1;
            default: pix_rdy = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Every cycle with pix_vld the head of the model queue must be on the outputs.
   always @(negedge clk) begin
      if (!rst && pix_vld) begin
         if (exp_q.size() == 0) chk("extra_pixel_vld", pix_vld, 0);
         else begin
            chk("pix_data", pix_data, exp_q[0].d);
            chk("pix_sof", pix_sof, exp_q[0].sof);
            chk("pix_eol", pix_eol, exp_q[0].eol);
            if (pix_rdy) begin
               void'(exp_q.pop_front());
               n_pop++;
            end
         end
      end
      if (!rst && lat_cyc >= 0) begin
         if (cyc == lat_cyc + 1) chk("latency_vld_at_1", pix_vld, 0);
         else if (cyc >= lat_cyc + 2) begin
            chk("latency_vld_at_2", pix_vld, 1);
            lat_cyc = -1;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic strobe(input logic h, input logic [7:0] d);
      if (gap_en) while ($urandom_range(0, 2) == 0) begin tick(); byte_vld = 1'b0; end
      tick();
      byte_vld  = 1'b1;
      cmos_href = h;
      cmos_db   = d;
   endtask

   task automatic set_cfg(input int x0, input int x1, input int y0, input int y1, input int d);
      cfg_x0 = 11'(x0); cfg_x1 = 11'(x1); cfg_y0 = 10'(y0); cfg_y1 = 10'(y1); cfg_decim = 2'(d);
   endtask

   // Model of one completed pixel at column x of the current model row.
   task automatic model_pix(input int x, input logic [15:0] v);
      exp_t e;
      bit   keep;
      keep = x >= m_x0 && x <= m_x1 && m_y >= m_y0 && m_y <= m_y1 &&
             ((x - m_x0) % m_step == 0) && ((m_y - m_y0) % m_step == 0);
      if (!keep) return;
      if (m_lim >= 0 && m_kept >= m_lim) return;
      e.d   = v;
      e.sof = !m_sof_seen;
      e.eol = (x + m_step > m_x1);
      if (!m_sof_seen && exp_q.size() == 0) lat_cyc = cyc;
      if (m_kept == 0) m_first = v;
      m_sof_seen = 1;
      m_kept++;
      if (e.eol) m_eol_cnt++;
      exp_q.push_back(e);
   endtask

   task automatic send_line(input int nbytes);
      logic [15:0] acc;
      logic [7:0]  v;
      acc = '0;
      for (int i = 0; i < nbytes; i++) begin
         if (seq_mode) begin v = seq_b; seq_b = seq_b + 8'h22; end
         else v = 8'($urandom_range(0, 255));
         strobe(1'b1, v);
         acc = {acc[7:0], v};
         if (i % BPP == BPP - 1) model_pix(i / BPP, acc);
      end
      strobe(1'b0, 8'h00);
      strobe(1'b0, 8'h00);
      if (nbytes >= BPP) m_y++;
   endtask

   task automatic frame_begin();
      cmos_vsync = 1'b1;
      repeat (4) strobe(1'b0, 8'h00);
      tick();
      byte_vld   = 1'b0;
      cmos_vsync = 1'b0;
      m_x0 = int'(cfg_x0); m_x1 = int'(cfg_x1); m_y0 = int'(cfg_y0); m_y1 = int'(cfg_y1);
      m_step = 1 << cfg_decim;
      m_y = 0; m_kept = 0; m_eol_cnt = 0; m_sof_seen = 0;
      m_frames++;
      strobe(1'b0, 8'h00);
      strobe(1'b0, 8'h00);
   endtask

   task automatic frame_end();
      tick();
      byte_vld   = 1'b0;
      cmos_vsync = 1'b1;
      repeat (3) strobe(1'b0, 8'h00);
   endtask

   task automatic send_frame(input int wpix, input int rows);
      frame_begin();
      for (int r = 0; r < rows; r++) send_line(wpix * BPP);
      frame_end();
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin tick(); n++; end
      chk({nm, "_drained_left"}, exp_q.size(), 0);
      repeat (4) tick();
   endtask

   initial begin
      int n0, w, rows;
      rst = 1'b1; cmos_vsync = 1'b1; cmos_href = 1'b0; cmos_db = '0; byte_vld = 1'b0; cfg_en = 1'b0;
      set_cfg(0, 3, 0, 1, 0);
      repeat (3) tick();
      chk("rst_pix_vld", pix_vld, 0);
      chk("rst_pix_data", pix_data, 0);
      chk("rst_pix_sof", pix_sof, 0);
      chk("rst_pix_eol", pix_eol, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick();
      cfg_en = 1'b1;

      // 4x2 frame, full window, sequential bytes.
      seq_mode = 1; seq_b = 8'h12; rdy_mode = 1;
      n0 = n_pop;
      send_frame(4, 2);
      drain("t1");
      chk("t1_model_kept", m_kept, 8);
      chk("t1_model_first", m_first, 16'h1234);
      chk("t1_model_eols", m_eol_cnt, 2);
      chk("t1_dut_pixels", n_pop - n0, 8);
      chk("t1_frame_cnt", frame_cnt, 1);
      chk("t1_busy", busy, 1);

      // Window x 2..9, y 1..5, decimation by 2 on a 12x8 frame.
      set_cfg(2, 9, 1, 5, 1);
      n0 = n_pop;
      send_frame(12, 8);
      drain("t2");
      chk("t2_model_kept", m_kept, 12);
      chk("t2_model_eols", m_eol_cnt, 3);
      chk("t2_dut_pixels", n_pop - n0, 12);
      chk("t2_frame_cnt", frame_cnt, 2);

      // A 1-byte line must neither produce a pixel nor advance the row.
      set_cfg(0, 15, 0, 0, 0);
      n0 = n_pop;
      frame_begin();
      send_line(1);
      send_line(8);
      send_line(3);
      frame_end();
      drain("t3");
      chk("t3_model_kept", m_kept, 4);
      chk("t3_dut_pixels", n_pop - n0, 4);

      // Inverted crop window keeps nothing but still counts the frame.
      set_cfg(5, 1, 0, 7, 0);
      n0 = n_pop;
      send_frame(6, 3);
      drain("t4");
      chk("t4_model_kept", m_kept, 0);
      chk("t4_dut_pixels", n_pop - n0, 0);
      chk("t4_frame_cnt", frame_cnt, 4);
      chk("t4_overflow", overflow, 0);

      // Random frames with random backpressure and byte gaps.
      seq_mode = 0; gap_en = 1; rdy_mode = 2;
      for (int f = 0; f < 10; f++) begin
         set_cfg($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 8),
                 $urandom_range(0, 8), $urandom_range(0, 3));
         rows = $urandom_range(1, 9);
         w    = $urandom_range(1, 14);
         frame_begin();
         for (int r = 0; r < rows; r++)
            send_line(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * w + 1) : 2 * w);
         frame_end();
         chk("rand_frame_cnt", frame_cnt, m_frames % 256);
      end
      drain("rand");
      chk("rand_no_overflow", overflow, 0);

      // Stalled sink over a 16-pixel row: 8 pixels survive, the rest of the frame is dropped.
      gap_en = 0; rdy_mode = 0;
      set_cfg(0, 15, 0, 1, 0);
      n0 = n_pop;
      m_lim = 8;
      frame_begin();
      send_line(32);
      chk("ovf_set", overflow, 1);
      chk("ovf_busy", busy, 1);
      send_line(32);
      frame_end();
      m_lim = -1;
      rdy_mode = 1;
      drain("ovf");
      chk("ovf_dut_pixels", n_pop - n0, 8);
      set_cfg(0, 3, 0, 1, 0);
      n0 = n_pop;
      send_frame(4, 2);
      drain("ovf_next");
      chk("ovf_next_pixels", n_pop - n0, 8);
      chk("ovf_sticky", overflow, 1);
      chk("ovf_frame_cnt", frame_cnt, m_frames % 256);

      // Asynchronous reset mid-frame with 3 pixels queued.
      rdy_mode = 0;
      set_cfg(0, 15, 0, 7, 0);
      frame_begin();
      send_line(6);
      repeat (4) tick();
      chk("prerst_vld", pix_vld, 1);
      @(posedge clk); #3;
      rst = 1'b1;
      exp_q.delete();
      lat_cyc  = -1;
      m_frames = 0;
      #1;
      chk("arst_pix_vld", pix_vld, 0);
      chk("arst_pix_data", pix_data, 0);
      chk("arst_sof_eol", {pix_sof, pix_eol}, 0);
      chk("arst_overflow", overflow, 0);
      chk("arst_frame_cnt", frame_cnt, 0);
      chk("arst_busy", busy, 0);
      tick(); tick();
      rst = 1'b0;
      repeat (6) tick();
      chk("postrst_vld", pix_vld, 0);
      rdy_mode = 1;
      set_cfg(0, 3, 0, 1, 0);
      n0 = n_pop;
      send_frame(4, 2);
      drain("postrst");
      chk("postrst_pixels", n_pop - n0, 8);
      chk("postrst_frame_cnt", frame_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
